// File: rtl/alu_ex_stage.sv
// Two-entry execute stage in front of the combinational ALU: operand register (S1),
// result register (S2) and a last-retired bypass (RET) that together cover every read-after-write window.
`timescale 1ns/1ps
module alu_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [RADDR-1:0] in_rd,
  input  logic [XLEN-1:0]  in_rs_val,
  input  logic [XLEN-1:0]  in_rt_val,
  input  logic [15:0]      in_imm,
  input  logic             in_use_imm,
  input  logic             in_sign_ext,
  output logic [XLEN-1:0]  alu_opa,
  output logic [XLEN-1:0]  alu_opb,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [RADDR-1:0] out_rd
);

  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [RADDR-1:0] r_s1_rs;
  logic [RADDR-1:0] r_s1_rt;
  logic [RADDR-1:0] r_s1_rd;
  logic [XLEN-1:0]  r_s1_rs_val;
  logic [XLEN-1:0]  r_s1_opb_raw;
  logic             r_s1_use_imm;

  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_res;
  logic [RADDR-1:0] r_s2_rd;

  logic             r_ret_valid;
  logic [RADDR-1:0] r_ret_rd;
  logic [XLEN-1:0]  r_ret_res;

  logic             w_adv2;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [XLEN-1:0]  w_imm_ext;
  logic [XLEN-1:0]  w_opb_raw;
  logic [XLEN-1:0]  w_opa;
  logic [XLEN-1:0]  w_opb;

  assign w_adv2   = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_s2_valid & out_ready;

  assign w_imm_ext = {{(XLEN-16){in_imm[15] & in_sign_ext}}, in_imm};
  assign w_opb_raw = in_use_imm ? w_imm_ext : in_rt_val;

  // S2 holds the younger producer, so it outranks RET; r0 is never bypassed.
  always_comb begin
    w_opa = r_s1_rs_val;
    if (r_s2_valid && (r_s2_rd == r_s1_rs) && (r_s1_rs != '0))
      w_opa = r_s2_res;
    else if (r_ret_valid && (r_ret_rd == r_s1_rs) && (r_s1_rs != '0))
      w_opa = r_ret_res;
  end

  always_comb begin
    w_opb = r_s1_opb_raw;
    if (!r_s1_use_imm) begin
      if (r_s2_valid && (r_s2_rd == r_s1_rt) && (r_s1_rt != '0))
        w_opb = r_s2_res;
      else if (r_ret_valid && (r_ret_rd == r_s1_rt) && (r_s1_rt != '0))
        w_opb = r_ret_res;
    end
  end

  assign alu_opa   = w_opa;
  assign alu_opb   = w_opb;
  assign alu_op    = r_s1_op;
  assign out_valid = r_s2_valid;
  assign out_res   = r_s2_res;
  assign out_rd    = r_s2_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_op      <= '0;
      r_s1_rs      <= '0;
      r_s1_rt      <= '0;
      r_s1_rd      <= '0;
      r_s1_rs_val  <= '0;
      r_s1_opb_raw <= '0;
      r_s1_use_imm <= 1'b0;
    end else if (w_in_hs) begin
      r_s1_valid   <= 1'b1;
      r_s1_op      <= in_op;
      r_s1_rs      <= in_rs;
      r_s1_rt      <= in_rt;
      r_s1_rd      <= in_rd;
      r_s1_rs_val  <= in_rs_val;
      r_s1_opb_raw <= w_opb_raw;
      r_s1_use_imm <= in_use_imm;
    end else if (w_adv2) begin
      r_s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_rd    <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= 1'b1;
      r_s2_res   <= alu_res;
      r_s2_rd    <= r_s1_rd;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // RET bridges the cycle between retirement and the register-file write being readable by decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_valid <= 1'b0;
      r_ret_rd    <= '0;
      r_ret_res   <= '0;
    end else if (w_out_hs) begin
      r_ret_valid <= 1'b1;
      r_ret_rd    <= r_s2_rd;
      r_ret_res   <= r_s2_res;
    end
  end

endmodule
